time_display_scanner: RTL
=========================

# time_display_scanner

Multiplexed 8-digit seven-segment driver that consumes the packed BCD time bus (hours tens … centiseconds ones, 4 bits per digit) and PM flag produced by the clock/alarm time blocks. It scans one digit at a time, latches a tear-free snapshot per frame, blanks between digits against ghosting, and supports whole-display blinking during set mode. It sits between the time-source mux and the board's anode/cathode pins.

## Interface
- REFRESH_DIVIDE, 5000: clock cycles per digit slot (1 kHz/digit, 125 Hz frame at 5 MHz); ≥ 2.
- BLANK_CYCLES, 50: cycles at the start of each slot with all anodes off; 1 ≤ BLANK_CYCLES < REFRESH_DIVIDE.
- BLINK_DIVIDE, 1250000: cycles per blink half-period (2 Hz blink at 5 MHz); ≥ 1.
- i_Clk_5MHz  in  1  system clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Time  in  32  packed BCD; [31:28] hours tens = digit 7 … [3:0] centiseconds ones = digit 0.
- i_PM  in  1  PM indicator, sampled with i_Time.
- i_Blink  in  1  1 = blank whole display during blink off-phase.
- o_Anodes  out  8  active-low digit enables; bit k = digit k.
- o_Segments  out  7  active-low cathodes, bit order {g,f,e,d,c,b,a}.
- o_DP  out  1  active-low decimal point.

## Operation
- Prescaler p counts 0..REFRESH_DIVIDE-1; digit index d advances when p = REFRESH_DIVIDE-1; d counts 0→7 then wraps to 0.
- Snapshot: {i_Time, i_PM} registered on the edge where p = 0 and d = 0 (frame start, including first cycle after reset); all displayed data comes from the snapshot only.
- Slot content for digit d from snapshot nibble d:
  - 0..9 → standard glyph: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10.
  - 10..15 → dash (g only) = 0x3F.
  - Digit 7 with value 0 → leading-zero blank: segments 0x7F, anode still enabled.
- DP lit (0) on digits 6, 4, 2 always; on digit 0 iff snapshot PM = 1; otherwise 1.
- Blanked cycle (p < BLANK_CYCLES, or i_Blink = 1 and blink phase = off): o_Anodes = 0xFF, o_Segments = 0x7F, o_DP = 1.
- Lit cycle: o_Anodes = ~(1 << d), o_Segments/o_DP per slot content.
- Blink counter free-runs 0..BLINK_DIVIDE-1 regardless of i_Blink; phase toggles on wrap; phase after reset = on (visible). i_Blink is applied combinationally to the current phase (no wait for phase edge).

## Timing
- All outputs registered; outputs at edge n+1 reflect p, d, blink phase, i_Blink and snapshot at cycle n (1-cycle latency).
- Reset values: p = 0, d = 0, blink counter = 0, phase = on, snapshot = 0 (time 0, PM 0), o_Anodes = 0xFF, o_Segments = 0x7F, o_DP = 1.
- Snapshot load coincides with a blanked cycle (BLANK_CYCLES ≥ 1), so new data never appears mid-slot.
- i_Time changes between frame starts are invisible until the next frame start; change on the capture edge itself is taken.
- Reset asserted mid-slot: next edge forces reset values; scan restarts at digit 0, slot starts blanked.
- Frame period = 8 × REFRESH_DIVIDE cycles exactly; no dropped or repeated slots.

## Structure
- Shared package: segment glyph constants (digits 0–9, DASH, BLANK), DP mask constant (digits 6, 4, 2), digit-count constant 8.
- Sub-module: bcd_to_seven_segment (combinational nibble → active-low glyph, dash for >9); instantiated once on the mux output.
- Top holds prescaler, digit index, blink counter, snapshot and output registers.

## Test plan
- Reset: hold i_Reset 3 cycles → o_Anodes = 0xFF, o_Segments = 0x7F, o_DP = 1; first lit cycle = digit 0 at cycle BLANK_CYCLES+1.
- Scan order (REFRESH_DIVIDE=4, BLANK_CYCLES=1, i_Time=0x12345678, PM=1): anodes 0xFE,0xFD,…,0x7F each lit 3 of 4 cycles; digit 0 segs 0x00 DP 0, digit 7 segs 0x79 DP 1, digit 6 DP 0.
- Leading zero/invalid: i_Time=0x0A595999 → digit 7 segs 0x7F with anode low, digit 6 segs 0x3F (dash).
- Tear-free: change i_Time 0x11111111→0x22222222 while d=3 → digits 3..7 still show 0x79 this frame; all 0x24 next frame.
- Blink (BLINK_DIVIDE=16): i_Blink=1 → display normal for 16 cycles, all off (0xFF) next 16, repeating; i_Blink=0 → never blanked by blink.
- Reset mid-scan at d=5, p=2 → next cycle outputs blank, following slot is digit 0, snapshot cleared to 0 then reloaded.

Source files
------------

// File: rtl/time_display_scanner_pkg.sv
// Shared constants for the multiplexed seven-segment time display.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package time_display_scanner_pkg;

    localparam int NUM_DIGITS = 8;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Digits whose decimal point is always lit: separators after hours,
    // minutes and seconds (digits 6, 4, 2)
    localparam logic [NUM_DIGITS-1:0] DP_MASK    = 8'b0101_0100;
    localparam logic [NUM_DIGITS-1:0] ANODES_OFF = 8'hFF;

    // Frame snapshot: BCD time plus PM flag, captured together
    typedef struct packed {
        logic [31:0] time_bcd;
        logic        pm;
    } snapshot_t;

endpackage

// File: rtl/time_display_scanner_bcd_to_seven_segment.sv
// Purpose: BCD nibble to active-low seven-segment glyph; non-decimal values show a dash.
// Latency: combinational.
// Backpressure: none.
module bcd_to_seven_segment
    import time_display_scanner_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Glyph lookup; anything above 9 is not a valid BCD digit and renders as a dash
    always_comb begin
        seg_o = SEG_DASH;
        case (nibble_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/time_display_scanner.sv
// Purpose: 8-digit multiplexed seven-segment scanner with per-frame snapshot, inter-digit blanking and blink.
// Latency: 1 cycle; outputs registered from the current scan state, snapshot and i_Blink.
// Backpressure: none; free-running scan, new time is taken only at frame start.
module time_display_scanner
    import time_display_scanner_pkg::*;
#(
    parameter int REFRESH_DIVIDE = 5000,
    parameter int BLANK_CYCLES   = 50,
    parameter int BLINK_DIVIDE   = 1250000
) (
    input  logic        i_Clk_5MHz,
    input  logic        i_Reset,
    input  logic [31:0] i_Time,
    input  logic        i_PM,
    input  logic        i_Blink,
    output logic [7:0]  o_Anodes,
    output logic [6:0]  o_Segments,
    output logic        o_DP
);

    localparam int PW = (REFRESH_DIVIDE > 1) ? $clog2(REFRESH_DIVIDE) : 1;
    localparam int BW = (BLINK_DIVIDE > 1) ? $clog2(BLINK_DIVIDE) : 1;

    logic [PW-1:0]  presc_q, presc_d;
    logic [2:0]     digit_q, digit_d;
    logic [BW-1:0]  blink_cnt_q, blink_cnt_d;
    logic           blink_on_q, blink_on_d;
    snapshot_t      snap_q, snap_d;
    logic [7:0]     anodes_q, anodes_d;
    logic [6:0]     segs_q, segs_d;
    logic           dp_q, dp_d;

    logic           presc_wrap;
    logic           blink_wrap;
    logic           frame_start;
    logic           blanked;
    logic [3:0]     digit_nib;
    logic [6:0]     digit_glyph;

    // Selected digit nibble drives the single shared decoder
    assign digit_nib = snap_q.time_bcd[{digit_q, 2'b00} +: 4];

    bcd_to_seven_segment u_decoder (
        .nibble_i (digit_nib),
        .seg_o    (digit_glyph)
    );

    // Scan timing: prescaler, digit index, free-running blink phase, frame snapshot
    always_comb begin
        presc_wrap  = (presc_q == PW'(REFRESH_DIVIDE - 1));
        blink_wrap  = (blink_cnt_q == BW'(BLINK_DIVIDE - 1));
        frame_start = (presc_q == '0) && (digit_q == 3'd0);

        presc_d     = presc_wrap ? '0 : presc_q + 1'b1;
        digit_d     = presc_wrap ? digit_q + 3'd1 : digit_q;
        blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
        blink_on_d  = blink_wrap ? ~blink_on_q : blink_on_q;
        // Frame start is always a blanked cycle, so the new snapshot
        // never shows up part-way through a slot
        snap_d      = frame_start ? '{time_bcd: i_Time, pm: i_PM} : snap_q;
    end

    // Output image for the next cycle: blank gap / blink-off, else the slot glyph
    always_comb begin
        blanked  = (presc_q < PW'(BLANK_CYCLES)) || (i_Blink && !blink_on_q);

        anodes_d = ANODES_OFF;
        segs_d   = SEG_BLANK;
        dp_d     = 1'b1;
        if (!blanked) begin
            anodes_d = ~(8'd1 << digit_q);
            // Hours-tens zero is suppressed but its anode still scans
            if (digit_q == 3'd7 && digit_nib == 4'd0) begin
                segs_d = SEG_BLANK;
            end else begin
                segs_d = digit_glyph;
            end
            if (digit_q == 3'd0) begin
                dp_d = ~snap_q.pm;
            end else begin
                dp_d = ~DP_MASK[digit_q];
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge i_Clk_5MHz) begin
        if (i_Reset) begin
            presc_q     <= '0;
            digit_q     <= 3'd0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            snap_q      <= '0;
            anodes_q    <= ANODES_OFF;
            segs_q      <= SEG_BLANK;
            dp_q        <= 1'b1;
        end else begin
            presc_q     <= presc_d;
            digit_q     <= digit_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            snap_q      <= snap_d;
            anodes_q    <= anodes_d;
            segs_q      <= segs_d;
            dp_q        <= dp_d;
        end
    end

    assign o_Anodes   = anodes_q;
    assign o_Segments = segs_q;
    assign o_DP       = dp_q;

endmodule
